wb_pipe_checker: RTL and testbench
==================================

// Module: wb_pipe_checker
// PURPOSE
//  Synthesizable run-time monitor for a pipelined Wishbone master port. Sits passively beside a
//  master/slave pair (sim or on-chip debug). Flags protocol violations: request instability under
//  stall, stray or over-limit acks, and transaction timeouts. Keeps the outstanding-request count
//  and a sticky first-fault record.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width; sel width is DW/8
//  CHECK_DATA  1   1: data/sel must also hold under stall on writes; 0: only addr/we checked
//  MAX_OUTST   4   max accepted-but-unacked requests; must be >=1
//  TIMEOUT     64  cycles without progress before a timeout error; 0 disables
// PORTS
//  i_clk          in   1     clock, all logic on rising edge
//  i_reset        in   1     synchronous, active-high reset
//  i_wb_cyc       in   1     master cycle
//  i_wb_stb       in   1     master strobe
//  i_wb_we        in   1     write enable
//  i_wb_addr      in   AW    address
//  i_wb_data      in   DW    write data
//  i_wb_sel       in   DW/8  byte selects
//  i_wb_stall     in   1     slave stall
//  i_wb_ack       in   1     slave ack
//  i_wb_err       in   1     slave bus error
//  o_outstanding  out  $clog2(MAX_OUTST+1)  accepted, unacked requests
//  o_state        out  2     IDLE=0, REQ=1, WAIT=2
//  o_err          out  7     one-cycle pulse per violation, bit map below
//  o_fault        out  1     sticky OR of all o_err bits
//  o_first_err    out  3     index of the lowest set o_err bit in the first faulting cycle
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. past_valid cleared; the first cycle after reset runs no
//    history-based checks (bits 0,1). Reset mid-transaction discards all history.
//  - accept = cyc&stb&!stall; resp = ack|err.
//    next outst = outst + accept - resp. Set to 0 when cyc is low or err is seen (abort).
//  - States: IDLE (cyc=0) -> REQ (cyc&stb) <-> WAIT (cyc&!stb&outst>0).
//    WAIT -> IDLE when the last resp arrives and stb=0, or when cyc drops.
//  - o_err bits, combinational on registered history, registered out (1-cycle latency):
//    [0] STB_DROP  past(cyc&stb&stall) & cyc & !stb
//    [1] REQ_CHG   past(cyc&stb&stall) & cyc & stb and addr or we changed. If CHECK_DATA and
//                  past(we), also data or sel changed.
//    [2] RESP_NOCYC  resp while !cyc
//    [3] RESP_EXTRA  resp & cyc & outst==0 (zero-latency acks are illegal)
//    [4] ACK_ERR     ack & err in the same cycle
//    [5] OVERFLOW    accept & !resp & outst==MAX_OUTST (count saturates at MAX_OUTST)
//    [6] TIMEOUT     no-progress count reaches TIMEOUT
//  - Timeout counter runs while cyc & (outst>0 | stb&stall). It clears on accept, resp or !cyc.
//    It saturates after flagging: one pulse per stall episode.
//  - Simultaneous accept & resp: count unchanged, no error.
//  - cyc drop with outst>0 is a legal abort: no error, count cleared.
//  - RESP_EXTRA: count is not decremented below 0.
//  - o_fault/o_first_err: latched on the first cycle with any o_err bit; held until reset.
// STRUCTURE
//  - wb_check_pkg: typedef enum wb_state_t {IDLE, REQ, WAIT}; localparam bit indices ERR_*
//    (0..6); localparam NERR=7.
//  - One sub-module, wb_check_timer (parameter TIMEOUT; in: run, clear; out: expire pulse).
//    Tie expire to 0 when TIMEOUT==0.
// TESTING
//  1. Reset, then cyc=stb=1, stall=1 for 3 cycles, addr 0x10 constant -> o_err=0, o_outstanding=0.
//     Then stall=0 -> o_outstanding=1 next cycle.
//  2. Under stall, addr changes 0x10->0x14 -> o_err[1] pulses one cycle later.
//     o_fault=1, o_first_err=1, both sticky.
//  3. Four accepts with no ack (MAX_OUTST=4), then a fifth accept -> o_err[5].
//     o_outstanding stays 4. One ack -> 3.
//  4. Ack with cyc=0 -> o_err[2]. Ack with cyc=1, outst=0 -> o_err[3]. ack&err together -> o_err[4].
//  5. One accept, then 64 cycles of no ack (TIMEOUT=64) -> single o_err[6] pulse.
//     Then cyc drop -> outst 0, IDLE, no new error.
//  6. Write under stall with data changing, CHECK_DATA=1 -> o_err[1]. Same with CHECK_DATA=0 -> none.
//     i_reset mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/wb_check_pkg.sv
// Shared types and error-bit map for the pipelined Wishbone protocol checker.
package wb_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } wb_state_t;

    localparam int NERR           = 7;
    localparam int ERR_STB_DROP   = 0;
    localparam int ERR_REQ_CHG    = 1;
    localparam int ERR_RESP_NOCYC = 2;
    localparam int ERR_RESP_EXTRA = 3;
    localparam int ERR_ACK_ERR    = 4;
    localparam int ERR_OVERFLOW   = 5;
    localparam int ERR_TIMEOUT    = 6;

    // Index of the lowest set error bit; 0 when none are set.
    function automatic logic [2:0] lowest_err(input logic [NERR-1:0] e);
        lowest_err = '0;
        for (int i = NERR - 1; i >= 0; i--) begin
            if (e[i]) lowest_err = 3'(i);
        end
    endfunction

endpackage

// File: rtl/wb_check_timer.sv
// No-progress watchdog: counts cycles while run is high, pulses expire once on reaching TIMEOUT.
module wb_check_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] count;

            // Holding at TIMEOUT keeps a long stall from producing a second pulse.
            always_ff @(posedge i_clk) begin
                if (i_reset || clear) begin
                    count <= '0;
                end else if (run && count != CW'(TIMEOUT)) begin
                    count <= count + 1'b1;
                end
            end

            assign expire = run && !clear && (count == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/wb_pipe_checker.sv
// Passive run-time monitor for a pipelined Wishbone master: flags protocol violations,
// tracks outstanding requests and keeps a sticky first-fault record.
module wb_pipe_checker
    import wb_check_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter bit CHECK_DATA = 1'b1,
    parameter int MAX_OUTST  = 4,
    parameter int TIMEOUT    = 64,
    localparam int OW        = $clog2(MAX_OUTST + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    output logic [OW-1:0]   o_outstanding,
    output logic [1:0]      o_state,
    output logic [NERR-1:0] o_err,
    output logic            o_fault,
    output logic [2:0]      o_first_err
);

    logic accept, resp, empty, at_max, expire;
    logic [OW-1:0] outst_next;
    logic [NERR-1:0] err_now;
    wb_state_t state_q, state_d;

    logic            past_valid, past_stall_req, past_we;
    logic [AW-1:0]   past_addr;
    logic [DW-1:0]   past_data;
    logic [DW/8-1:0] past_sel;

    assign accept = i_wb_cyc && i_wb_stb && !i_wb_stall;
    assign resp   = i_wb_ack || i_wb_err;
    assign empty  = (o_outstanding == '0);
    assign at_max = (o_outstanding == OW'(MAX_OUTST));

    always_comb begin
        outst_next = o_outstanding;
        if (!i_wb_cyc || i_wb_err) begin
            outst_next = '0;
        end else if (accept && !resp) begin
            if (!at_max) outst_next = o_outstanding + 1'b1;
        end else if (!accept && resp) begin
            if (!empty) outst_next = o_outstanding - 1'b1;
        end
    end

    // NOTE: only the qualifiers are reset; the captured request fields are ignored
    // until past_stall_req is set, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            past_valid     <= 1'b0;
            past_stall_req <= 1'b0;
        end else begin
            past_valid     <= 1'b1;
            past_stall_req <= i_wb_cyc && i_wb_stb && i_wb_stall;
        end
        past_we   <= i_wb_we;
        past_addr <= i_wb_addr;
        past_data <= i_wb_data;
        past_sel  <= i_wb_sel;
    end

    wb_check_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .run     (i_wb_cyc && (!empty || (i_wb_stb && i_wb_stall))),
        .clear   (accept || resp || !i_wb_cyc),
        .expire  (expire)
    );

    always_comb begin
        logic held, req_chg;
        err_now = '0;
        held    = past_valid && past_stall_req && i_wb_cyc;
        req_chg = (i_wb_addr != past_addr) || (i_wb_we != past_we);
        if (CHECK_DATA && past_we) begin
            req_chg = req_chg || (i_wb_data != past_data) || (i_wb_sel != past_sel);
        end
        err_now[ERR_STB_DROP]   = held && !i_wb_stb;
        err_now[ERR_REQ_CHG]    = held && i_wb_stb && req_chg;
        err_now[ERR_RESP_NOCYC] = resp && !i_wb_cyc;
        err_now[ERR_RESP_EXTRA] = resp && i_wb_cyc && empty;
        err_now[ERR_ACK_ERR]    = i_wb_ack && i_wb_err;
        err_now[ERR_OVERFLOW]   = accept && !resp && at_max;
        err_now[ERR_TIMEOUT]    = expire;
    end

    always_comb begin
        state_d = IDLE;
        if (i_wb_cyc) begin
            if (i_wb_stb)                state_d = REQ;
            else if (outst_next != '0)   state_d = WAIT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            o_outstanding <= '0;
            o_err         <= '0;
            o_fault       <= 1'b0;
            o_first_err   <= '0;
        end else begin
            state_q       <= state_d;
            o_outstanding <= outst_next;
            o_err         <= err_now;
            if (!o_fault && (|err_now)) begin
                o_fault     <= 1'b1;
                o_first_err <= lowest_err(err_now);
            end
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_wb_pipe_checker.sv
// Scoreboard bench for wb_pipe_checker: directed bus cycles push expected outputs, a monitor compares.
module tb_wb_pipe_checker;

    localparam logic [6:0] SAME = 7'h7f;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        wb_cyc = 0, wb_stb = 0, wb_we = 0, wb_stall = 0, wb_ack = 0, wb_err = 0;
    logic [31:0] wb_addr = '0, wb_data = '0;
    logic [3:0]  wb_sel = '0;

    logic [2:0] outst1, outst2, first1, first2;
    logic [1:0] state1, state2;
    logic [6:0] err1, err2;
    logic       fault1, fault2;

    typedef struct {
        string      nm;
        logic [6:0] err;
        logic [6:0] err2;
        logic [2:0] outst;
        logic [1:0] st;
        logic       fault;
        logic [2:0] first;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic       ef = 1'b0;
    logic [2:0] efirst = '0;

    always #5 i_clk = ~i_clk;

    wb_pipe_checker #(.CHECK_DATA(1'b1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_sel(wb_sel), .i_wb_stall(wb_stall),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_outstanding(outst1), .o_state(state1),
        .o_err(err1), .o_fault(fault1), .o_first_err(first1)
    );

    wb_pipe_checker #(.CHECK_DATA(1'b0)) dut_nd (
        .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_sel(wb_sel), .i_wb_stall(wb_stall),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .o_outstanding(outst2), .o_state(state2),
        .o_err(err2), .o_fault(fault2), .o_first_err(first2)
    );

    task automatic push(input string nm, input logic [6:0] ee, input int eo, input int es,
                        input logic [6:0] ee2);
        exp_t x;
        x.nm    = nm;
        x.err   = ee;
        x.err2  = (ee2 == SAME) ? ee : ee2;
        x.outst = 3'(eo);
        x.st    = 2'(es);
        x.fault = ef;
        x.first = efirst;
        q.push_back(x);
    endtask

    // One bus cycle; expectation is what the outputs show after this cycle's edge.
    task automatic step(input string nm, input logic c, input logic s, input logic stl,
                        input logic a, input logic e, input logic [6:0] ee, input int eo,
                        input int es, input logic [6:0] ee2 = SAME);
        wb_cyc = c; wb_stb = s; wb_stall = stl; wb_ack = a; wb_err = e;
        @(posedge i_clk);
        #1;
        push(nm, ee, eo, es, ee2);
    endtask

    task automatic rst(input string nm);
        i_reset = 1'b1;
        ef = 1'b0;
        efirst = '0;
        @(posedge i_clk);
        #1;
        push(nm, 7'h00, 0, 0, SAME);
        i_reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge i_clk);
            if (q.size() != 0) begin
                x = q.pop_front();
                n_cmp++;
                if ({err1, err2, outst1, state1, fault1, first1} !==
                    {x.err, x.err2, x.outst, x.st, x.fault, x.first}) begin
                    n_bad++;
                    $display("FAIL %s: got err=%h err_nd=%h outst=%0d state=%0d fault=%b first=%0d, expected err=%h err_nd=%h outst=%0d state=%0d fault=%b first=%0d",
                             x.nm, err1, err2, outst1, state1, fault1, first1,
                             x.err, x.err2, x.outst, x.st, x.fault, x.first);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst("reset");

        // Stable request under stall, then acceptance.
        wb_addr = 32'h10; wb_we = 1'b0;
        repeat (3) step("stall_hold", 1, 1, 1, 0, 0, 7'h00, 0, 1);
        step("accept_first", 1, 1, 0, 0, 0, 7'h00, 1, 1);
        step("ack_first",    1, 0, 0, 1, 0, 7'h00, 0, 0);
        step("idle",         0, 0, 0, 0, 0, 7'h00, 0, 0);

        // Address change under stall; fault record becomes sticky.
        step("stall_a10", 1, 1, 1, 0, 0, 7'h00, 0, 1);
        wb_addr = 32'h14; ef = 1'b1; efirst = 3'd1;
        step("addr_chg",    1, 1, 1, 0, 0, 7'h02, 0, 1);
        step("accept_a14",  1, 1, 0, 0, 0, 7'h00, 1, 1);
        step("ack_a14",     1, 0, 0, 1, 0, 7'h00, 0, 0);
        step("idle_sticky", 0, 0, 0, 0, 0, 7'h00, 0, 0);

        // Fill to MAX_OUTST, then overflow; first_err stays at the earlier fault.
        for (int k = 1; k <= 4; k++) step("fill", 1, 1, 0, 0, 0, 7'h00, k, 1);
        step("overflow",   1, 1, 0, 0, 0, 7'h20, 4, 1);
        step("drain_one",  1, 0, 0, 1, 0, 7'h00, 3, 2);
        step("abort_drop", 0, 0, 0, 0, 0, 7'h00, 0, 0);

        // Response errors.
        rst("reset_t4");
        ef = 1'b1; efirst = 3'd2;
        step("ack_nocyc",      0, 0, 0, 1, 0, 7'h04, 0, 0);
        step("ack_extra",      1, 0, 0, 1, 0, 7'h08, 0, 0);
        step("accept_one",     1, 1, 0, 0, 0, 7'h00, 1, 1);
        step("accept_and_ack", 1, 1, 0, 1, 0, 7'h00, 1, 1);
        step("ack_and_err",    1, 0, 0, 1, 1, 7'h10, 0, 0);
        step("idle_t4",        0, 0, 0, 0, 0, 7'h00, 0, 0);

        // Timeout after 64 cycles without progress, exactly one pulse.
        rst("reset_t5");
        step("accept_to", 1, 1, 0, 0, 0, 7'h00, 1, 1);
        for (int k = 1; k <= 64; k++) begin
            if (k == 64) begin ef = 1'b1; efirst = 3'd6; end
            step("timeout_wait", 1, 0, 0, 0, 0, (k == 64) ? 7'h40 : 7'h00, 1, 2);
        end
        repeat (3) step("to_saturated", 1, 0, 0, 0, 0, 7'h00, 1, 2);
        step("to_abort", 0, 0, 0, 0, 0, 7'h00, 0, 0);

        // Write data change under stall: flagged only when data is checked.
        rst("reset_t6");
        wb_we = 1'b1; wb_addr = 32'h20; wb_data = 32'hAAAA_0000; wb_sel = 4'hF;
        step("wr_stall", 1, 1, 1, 0, 0, 7'h00, 0, 1);
        wb_data = 32'hBBBB_0000; ef = 1'b1; efirst = 3'd1;
        step("wr_data_chg", 1, 1, 1, 0, 0, 7'h02, 0, 1, 7'h00);
        step("wr_accept",   1, 1, 0, 0, 0, 7'h00, 1, 1);

        // Reset mid-burst discards history.
        wb_stall = 1'b1;
        rst("reset_mid_burst");
        wb_addr = 32'h24;
        step("post_reset_chg",  1, 1, 1, 0, 0, 7'h00, 0, 1);
        step("post_reset_hold", 1, 1, 1, 0, 0, 7'h00, 0, 1);
        ef = 1'b1; efirst = 3'd0;
        step("stb_drop", 1, 0, 0, 0, 0, 7'h01, 0, 0);
        step("end",      0, 0, 0, 0, 0, 7'h00, 0, 0);

        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            @(negedge i_clk);
            #1;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
